// File: rtl/load_down_counter_pkg.sv
// Shared types and constants for the loadable down-counter.
// Holds the FSM state encoding and the default counter width.
package load_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : load_down_counter_pkg

// File: rtl/load_down_counter.sv
// Loadable down-counter with optional auto-reload and a one-cycle terminal-count pulse.
// The FSM (IDLE/RUN/DONE) and all outputs are registered; next-state logic is combinational.
module load_down_counter
  import load_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             auto_reload_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_reload_next;
  logic             w_tc_next;

  // Load overrides everything; otherwise only RUN counts and only DONE reacts to ack.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_tc_next     = 1'b0;
    if (load_i) begin
      w_count_next  = load_val_i;
      w_reload_next = load_val_i;
      if (load_val_i == '0) begin
        w_state_next = DONE;
        w_tc_next    = 1'b1;
      end else begin
        w_state_next = RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (en_i) begin
            if (r_count == WIDTH'(1)) begin
              w_tc_next = 1'b1;
              if (auto_reload_i) begin
                w_count_next = r_reload;
              end else begin
                w_count_next = '0;
                w_state_next = DONE;
              end
            end else if (r_count > WIDTH'(1)) begin
              w_count_next = r_count - WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (ack_i) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with count_o.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_tc     <= w_tc_next;
      r_busy   <= (w_state_next == RUN);
      r_done   <= (w_state_next == DONE);
    end
  end

  assign count_o = r_count;
  assign tc_o    = r_tc;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule : load_down_counter

// File: doc/load_down_counter.md
LOAD_DOWN_COUNTER -- requirements
Module: load_down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and load-value width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 load_i  input  1  load strobe; samples load_val_i and starts a countdown.
REQ-005 load_val_i  input  WIDTH  start value and reload value.
REQ-006 en_i  input  1  count enable; decrement only when high.
REQ-007 auto_reload_i  input  1  at the terminal edge: 1 = restart from the stored value, 0 = stop in DONE.
REQ-008 ack_i  input  1  acknowledge; releases DONE.
REQ-009 count_o  output  WIDTH  current count, registered.
REQ-010 tc_o  output  1  terminal-count pulse, registered, exactly one cycle wide.
REQ-011 busy_o  output  1  high while in RUN.
REQ-012 done_o  output  1  high while in DONE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; busy_o = (state==RUN); done_o = (state==DONE).
REQ-014 load_i=1 in any state SHALL load count_o and reload_reg from load_val_i on that edge; load SHALL have priority over en_i, ack_i and terminal events.
REQ-015 Load of a nonzero value SHALL go to RUN with tc_o=0 next cycle.
REQ-016 Load of zero SHALL go to DONE with count_o=0 and tc_o=1 for one cycle.
REQ-017 In RUN with en_i=1 and count_o>1: count_o decrements by 1 per cycle.
REQ-018 In RUN with en_i=0: count_o and state hold; no tc_o.
REQ-019 Terminal edge: RUN, en_i=1, count_o==1, load_i=0.
REQ-020 Terminal edge with auto_reload_i=0: count_o becomes 0, state goes to DONE, tc_o=1 next cycle.
REQ-021 Terminal edge with auto_reload_i=1: count_o becomes reload_reg, state stays RUN, tc_o=1 next cycle; period = loaded value in enabled cycles.
REQ-022 Load coincident with the terminal edge: the load wins and tc_o stays 0.
REQ-023 DONE holds count_o=0 until ack_i=1, then goes to IDLE; a simultaneous load follows REQ-014 instead.
REQ-024 IDLE holds count_o; en_i and ack_i are ignored there.
REQ-025 Arithmetic is unsigned WIDTH-bit. count_o never wraps below 0; load_val_i = 2^WIDTH-1 is legal and gives 2^WIDTH-1 enabled cycles to terminal.
REQ-026 tc_o SHALL never be high on two consecutive cycles except with auto-reload and reload value 1.

Reset
REQ-027 reset=0 at an edge SHALL force state=IDLE, count_o=0, reload_reg=0, tc_o=0, busy_o=0, done_o=0, overriding all other inputs.
REQ-028 Reset mid-RUN or mid-DONE SHALL discard the countdown; no tc_o pulse is produced by reset.
REQ-029 The first edge with reset=1 SHALL evaluate inputs normally.

Structure
REQ-030 Shared package load_down_counter_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-031 Single module; no sub-module. Next-state/next-count logic is combinational and state/count/tc/reload_reg are registers.

Verification
REQ-032 Reset: hold reset=0 for 2 cycles with load_i=1 and load_val_i=4'h7 -> count_o=0, tc_o=0, busy_o=0, done_o=0.
REQ-033 Countdown: load 4'hF, en_i=1, auto_reload_i=0 -> count_o 15..1, then 0 after 15 cycles with tc_o=1 for exactly one cycle; done_o held until ack_i pulse, then IDLE.
REQ-034 Enable gating: load 5, en_i=1 for 2 cycles then 0 for 3 cycles -> count_o holds 3 and busy_o stays 1.
REQ-035 Auto-reload: load 3, en_i=1, auto_reload_i=1 -> count_o 3,2,1,3,2,1,...; tc_o=1 each cycle count_o returns to 3; count_o never 0.
REQ-036 Collision: count_o=1, en_i=1, load_i=1 with load_val_i=9 on the same edge -> count_o=9, tc_o=0, state RUN.
REQ-037 Edge cases: load 0 -> count_o=0, tc_o one-cycle pulse, done_o=1. Reset asserted at count_o=6 in RUN -> IDLE, count_o=0, no tc_o.
